ddr3_byte_write_packer: RTL



---
 rtl/ddr_wr_pkg.sv | 19 +
 rtl/wr_idle_timer.sv | 37 +++
 rtl/ddr3_byte_write_packer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR3 byte write packer and its idle timer.
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    FILL     = 2'd1,
    WRITE    = 2'd2
  } wr_state_e;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam int APP_DATA_W = 256;
  localparam int APP_MASK_W = 32;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wr_idle_timer.sv
// Idle-cycle counter for the write packer: flags expiry on the TIMEOUT_CYC-th
// consecutive idle cycle, then restarts from zero.
module wr_idle_timer
  import ddr_wr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic srst,
  input  logic idle,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = idle && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (idle && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr3_byte_write_packer.sv
// Packs a byte stream into 256-bit words and writes them to sequential DDR3
// addresses via the MIG app interface. Define WR_PACKER_TIMEOUT_EN for idle auto-flush.
module ddr3_byte_write_packer
  import ddr_wr_pkg::*;
#(
  parameter int              ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              FRAME_WORDS = 24576,
  parameter int              ADDR_STEP   = 8,
  parameter int              TIMEOUT_CYC = 1000000
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  init_calib_complete,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [APP_DATA_W-1:0] app_wdf_data,
  output logic                  app_wdf_end,
  output logic                  app_wdf_wren,
  output logic [APP_MASK_W-1:0] app_wdf_mask,
  input  logic                  app_wdf_rdy,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [1:0] S_WAIT_CAL = WAIT_CAL;
  localparam logic [1:0] S_FILL     = FILL;
  localparam logic [1:0] S_WRITE    = WRITE;

  localparam int WC_W = cnt_width(FRAME_WORDS);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);

  logic [1:0]            state_q, state_d;
  logic [4:0]            byte_cnt_q, byte_cnt_d;
  logic [APP_DATA_W-1:0] data_q, data_d;
  logic [APP_MASK_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  data_done_q, data_done_d;
  logic                  frame_done_q, frame_done_d;

  logic                  accept;
  logic                  flush_req;
  logic                  timeout_hit;
  logic                  cmd_fire;
  logic                  data_fire;
  logic [APP_MASK_W-1:0] lane_sel;

  assign in_ready     = (state_q == S_FILL);
  assign accept       = in_valid && in_ready;
  assign app_en       = (state_q == S_WRITE) && !cmd_done_q;
  assign app_wdf_wren = (state_q == S_WRITE) && !data_done_q;
  assign app_wdf_end  = app_wdf_wren;
  assign cmd_fire     = app_en && app_rdy;
  assign data_fire    = app_wdf_wren && app_wdf_rdy;
  assign flush_req    = flush || timeout_hit;

  assign app_cmd      = APP_CMD_WRITE;
  assign app_addr     = addr_q;
  assign app_wdf_data = data_q;
  assign app_wdf_mask = mask_q;
  assign frame_done   = frame_done_q;
  assign busy         = !((state_q == S_FILL) && (byte_cnt_q == 5'd0));

  genvar gi;
  generate
    for (gi = 0; gi < APP_MASK_W; gi++) begin : g_lane
      assign lane_sel[gi] = (byte_cnt_q == 5'(gi));
    end
  endgenerate

`ifdef WR_PACKER_TIMEOUT_EN
  logic idle_cycle;
  assign idle_cycle = (state_q == S_FILL) && (byte_cnt_q != 5'd0) && !accept;

  wr_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (ui_clk),
    .srst   (ui_clk_sync_rst),
    .idle   (idle_cycle),
    .expired(timeout_hit)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    data_d       = data_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    cmd_done_d   = cmd_done_q;
    data_done_d  = data_done_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_WAIT_CAL: begin
        if (init_calib_complete) begin
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (accept) begin
          for (int i = 0; i < APP_MASK_W; i++) begin
            if (lane_sel[i]) begin
              data_d[8*i +: 8] = in_data;
              mask_d[i]        = 1'b0;
            end
          end
          byte_cnt_d = byte_cnt_q + 5'd1;
        end
        // A flush coinciding with a byte still writes that byte into the word.
        if ((accept && (byte_cnt_q == 5'd31)) ||
            (flush_req && (accept || (byte_cnt_q != 5'd0)))) begin
          state_d     = S_WRITE;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
        end
      end

      S_WRITE: begin
        cmd_done_d  = cmd_done_q || cmd_fire;
        data_done_d = data_done_q || data_fire;
        if (cmd_done_d && data_done_d) begin
          state_d     = S_FILL;
          byte_cnt_d  = 5'd0;
          data_d      = '0;
          mask_d      = '1;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          if (word_cnt_q == LAST_WORD) begin
            addr_d       = BASE_ADDR;
            word_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            addr_d     = addr_q + ADDR_W'(ADDR_STEP);
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
      end

      default: begin
        state_d = S_WAIT_CAL;
      end
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q      <= S_WAIT_CAL;
      byte_cnt_q   <= 5'd0;
      data_q       <= '0;
      mask_q       <= '1;
      addr_q       <= BASE_ADDR;
      word_cnt_q   <= '0;
      cmd_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      cmd_done_q   <= cmd_done_d;
      data_done_q  <= data_done_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
